// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX sides.
//   uart_state_e : frame sequencer states
//   PAR_EVEN/ODD : parity type encoding as seen on the Parity_Type pin
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART engines.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   clear    force the counter to 0 (frame accept / idle)
//   cnt      current position inside the bit period, 0..CLKS_PER_BIT-1
//   bit_end  high during the last cycle of a bit period
module uart_bit_timer #(
    parameter int unsigned  CLKS_PER_BIT = 16,
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             bit_end
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stops.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   Data_Valid    request to send P_DATA (taken only while idle)
//   P_DATA        word to send
//   Parity_EN     insert parity bit
//   Parity_Type   0 even, 1 odd
//   Two_Stop      send two stop bits
//   TX_OUT        registered serial line, idle high
//   Busy          high from accept until the frame completes
//   Done          one-cycle pulse in the last cycle of the final stop bit
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Parity_EN,
    input  logic                  Parity_Type,
    input  logic                  Two_Stop,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

    uart_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  two_stop_q, two_stop_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  bit_end;
    logic [CNT_W-1:0]      cnt;
    logic                  par_bit;
    logic                  final_stop;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept || (state_d == IDLE)),
        .cnt     (cnt),
        .bit_end (bit_end)
    );

    assign par_bit    = (par_type_q == PAR_ODD) ? ~^data_q : ^data_q;
    assign final_stop = (state_q == STOP2) || ((state_q == STOP1) && !two_stop_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        accept     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP1;
            end
            STOP1: begin
                if (bit_end) state_d = two_stop_q ? STOP2 : IDLE;
            end
            STOP2: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Frame configuration is frozen at accept; later input changes are ignored.
        data_d     = accept ? P_DATA      : data_q;
        par_en_d   = accept ? Parity_EN   : par_en_q;
        par_type_d = accept ? Parity_Type : par_type_q;
        two_stop_d = accept ? Two_Stop    : two_stop_q;

        // Outputs are registered from next-state values so they align with the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[idx_d];
            PARITY:  tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        // Counter reaches its last value next cycle, inside the final stop bit.
        done_d = final_stop && (cnt == CNT_W'(CLKS_PER_BIT - 2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv8, dv5;
    logic [7:0] pd8;
    logic [4:0] pd5;
    logic       pen, ptype, two;
    logic       tx8, busy8, done8;
    logic       tx5, busy5, done5;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (16)
    ) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .Data_Valid  (dv8),
        .P_DATA      (pd8),
        .Parity_EN   (pen),
        .Parity_Type (ptype),
        .Two_Stop    (two),
        .TX_OUT      (tx8),
        .Busy        (busy8),
        .Done        (done8)
    );

    uart_tx_engine #(
        .DATA_WIDTH   (5),
        .CLKS_PER_BIT (4)
    ) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .Data_Valid  (dv5),
        .P_DATA      (pd5),
        .Parity_EN   (pen),
        .Parity_Type (ptype),
        .Two_Stop    (two),
        .TX_OUT      (tx5),
        .Busy        (busy5),
        .Done        (done5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of frame cycle 1 (one edge after accept).
    // bits[i] is the hand-computed line level of bit period i.
    task automatic run_frame(input bit sel, input int nbits, input int cpb,
                             input logic [15:0] bits, input int glitch, input string name);
        int total = nbits * cpb;
        for (int c = 1; c <= total; c++) begin
            if (glitch != 0 && c == glitch) begin
                dv8   = 1'b1;
                pd8   = 8'hFF;
                two   = ~two;
                ptype = ~ptype;
                pen   = ~pen;
            end
            if (glitch != 0 && c == glitch + 1) dv8 = 1'b0;
            check($sformatf("%s tx c%0d", name, c), sel ? tx5 : tx8, bits[(c - 1) / cpb]);
            check($sformatf("%s busy c%0d", name, c), sel ? busy5 : busy8, 1'b1);
            check($sformatf("%s done c%0d", name, c), sel ? done5 : done8, (c == total));
            @(negedge clk);
        end
        check($sformatf("%s idle tx", name), sel ? tx5 : tx8, 1'b1);
        check($sformatf("%s idle busy", name), sel ? busy5 : busy8, 1'b0);
        check($sformatf("%s idle done", name), sel ? done5 : done8, 1'b0);
    endtask

    initial begin
        int done_seen;
        int low_seen;

        rst_n = 1'b0;
        dv8 = 1'b0; dv5 = 1'b0; pd8 = '0; pd5 = '0;
        pen = 1'b0; ptype = 1'b0; two = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx8", tx8, 1'b1);
        check("rst busy8", busy8, 1'b0);
        check("rst done8", done8, 1'b0);
        check("rst tx5", tx5, 1'b1);
        check("rst busy5", busy5, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0xA5
        dv8 = 1'b1; pd8 = 8'hA5; pen = 1'b0; two = 1'b0;
        @(negedge clk);
        dv8 = 1'b0;
        run_frame(1'b0, 10, 16, {6'b0, 1'b1, 8'hA5, 1'b0}, 0, "8N1_A5");

        // 8E1 0x07, even parity bit = 1
        dv8 = 1'b1; pd8 = 8'h07; pen = 1'b1; ptype = 1'b0; two = 1'b0;
        @(negedge clk);
        dv8 = 1'b0;
        run_frame(1'b0, 11, 16, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 0, "8E1_07");

        // 8O1 0x07, odd parity bit = 0; mid-frame request with 0xFF and flipped config ignored
        dv8 = 1'b1; pd8 = 8'h07; pen = 1'b1; ptype = 1'b1; two = 1'b0;
        @(negedge clk);
        dv8 = 1'b0;
        run_frame(1'b0, 11, 16, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 50, "8O1_07");

        // 8O2 0x00 with Data_Valid held through Done; second frame one cycle after Done
        dv8 = 1'b1; pd8 = 8'h00; pen = 1'b1; ptype = 1'b1; two = 1'b1;
        @(negedge clk);
        run_frame(1'b0, 12, 16, {4'b0, 2'b11, 1'b1, 8'h00, 1'b0}, 0, "8O2_00");
        pd8 = 8'h3C; pen = 1'b0; two = 1'b0;
        @(negedge clk);
        dv8 = 1'b0;
        run_frame(1'b0, 10, 16, {6'b0, 1'b1, 8'h3C, 1'b0}, 0, "8N1_3C");

        // 5-bit, 4 clocks per bit, 0x13
        dv5 = 1'b1; pd5 = 5'h13; pen = 1'b0; two = 1'b0;
        @(negedge clk);
        dv5 = 1'b0;
        run_frame(1'b1, 7, 4, {9'b0, 1'b1, 5'h13, 1'b0}, 0, "5N1_13");

        // Reset held 3 cycles mid-frame aborts the frame with no Done
        dv8 = 1'b1; pd8 = 8'hA5; pen = 1'b0; two = 1'b0;
        @(negedge clk);
        dv8 = 1'b0;
        repeat (20) @(negedge clk);
        check("pre-rst busy8", busy8, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst tx8", tx8, 1'b1);
        check("midrst busy8", busy8, 1'b0);
        check("midrst done8", done8, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        low_seen  = 0;
        for (int i = 0; i < 200; i++) begin
            if (done8 !== 1'b0) done_seen++;
            if (tx8 !== 1'b1 || busy8 !== 1'b0) low_seen++;
            @(negedge clk);
        end
        check("post-rst done count", done_seen, 0);
        check("post-rst line activity", low_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
